// File: rtl/dbuffer_access_ctrl.sv
// MEM-stage data-buffer responder: accepts pre-checked load/store requests, drives a
// 256-word synchronous SRAM with byte-lane enables, and returns a one-cycle response.
module dbuffer_access_ctrl #(
  parameter int IDX_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              load,
  input  logic              store,
  input  logic [2:0]        func3,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic              addr_ok,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("dbuffer_access_ctrl: only RD_LAT=1 is supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [1:0]        r_lane;
  logic [2:0]        r_func3;
  logic              r_store;

  state_t            w_state_nxt;
  logic [1:0]        w_lane_nxt;
  logic [2:0]        w_func3_nxt;
  logic              w_store_nxt;
  logic              w_mem_en_nxt;
  logic [3:0]        w_mem_we_nxt;
  logic [IDX_W-1:0]  w_mem_addr_nxt;
  logic [31:0]       w_mem_wdata_nxt;
  logic              w_resp_valid_nxt;
  logic              w_resp_err_nxt;
  logic [31:0]       w_rdata_nxt;
  logic              w_accept;
  logic              w_err;
  logic              w_unused_addr;

  assign w_unused_addr = ^address[31:IDX_W+2];

  function automatic logic [3:0] f_store_we(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // func3[2] selects zero extension; otherwise the top lane bit is replicated.
  function automatic logic [31:0] f_load_extract(input logic [31:0] d, input logic [1:0] a,
                                                 input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    case (f3[1:0])
      2'b00:   return {{24{b[7] & ~f3[2]}}, b};
      2'b01:   return {{16{h[15] & ~f3[2]}}, h};
      default: return d;
    endcase
  endfunction

  assign w_accept  = req_valid & (r_state == S_IDLE) & (load | store);
  assign w_err     = ~addr_ok | (load & store) | (func3 == 3'b011) | (func3[2:1] == 2'b11)
                   | (store & func3[2]);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt      = r_state;
    w_lane_nxt       = r_lane;
    w_func3_nxt      = r_func3;
    w_store_nxt      = r_store;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = 4'b0000;
    w_mem_addr_nxt   = mem_addr;
    w_mem_wdata_nxt  = mem_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_rdata_nxt      = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_lane_nxt     = address[1:0];
          w_func3_nxt    = func3;
          w_store_nxt    = store;
          w_mem_addr_nxt = address[IDX_W+1:2];
          if (w_err) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = S_ACCESS;
            w_mem_en_nxt = 1'b1;
            if (store) begin
              w_mem_we_nxt    = f_store_we(func3, address[1:0]);
              w_mem_wdata_nxt = f_store_data(func3, wdata);
            end
          end
        end
      end
      S_ACCESS: begin
        if (r_store) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_rdata_nxt      = f_load_extract(mem_rdata, r_lane, r_func3);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and every registered output; reset also drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lane     <= 2'b00;
      r_func3    <= 3'b000;
      r_store    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane     <= w_lane_nxt;
      r_func3    <= w_func3_nxt;
      r_store    <= w_store_nxt;
      mem_en     <= w_mem_en_nxt;
      mem_we     <= w_mem_we_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
      resp_valid <= w_resp_valid_nxt;
      resp_err   <= w_resp_err_nxt;
      rdata      <= w_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dbuffer_access_ctrl.sv
// Directed bench for dbuffer_access_ctrl with a behavioural SRAM and an expected-response queue.
module tb_dbuffer_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, load, store, addr_ok;
  logic [2:0]  func3;
  logic [31:0] address, wdata, rdata, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, busy, mem_en;
  logic [3:0]  mem_we;
  logic [7:0]  mem_addr;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sram [256];

  always #5 clk = ~clk;

  dbuffer_access_ctrl #(.IDX_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .load(load), .store(store), .func3(func3), .address(address), .wdata(wdata),
    .addr_ok(addr_ok), .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous SRAM with one-cycle read latency and byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      else
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic ok);
    @(negedge clk);
    req_valid = 1'b1; load = ld; store = st; func3 = f3;
    address = addr; wdata = wd; addr_ok = ok;
    @(posedge clk); #1;
    req_valid = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; latency counts from that edge.
  task automatic wait_resp(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      chk({tag, "_ready_busy"}, req_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_ready_resp"}, req_ready, 0);
    e = q.pop_front();
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_err"}, resp_err, e.err);
    chk({tag, "_rdata"}, rdata, e.rdata);
    @(posedge clk); #1;
    chk({tag, "_valid_clr"}, resp_valid, 0);
    chk({tag, "_ready_idle"}, req_ready, 1);
    chk({tag, "_rdata_clr"}, rdata, 0);
  endtask

  task automatic xact(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic ok,
                      input logic e_err, input logic [31:0] e_rd, input int e_lat,
                      input logic [3:0] e_we, input logic [31:0] e_wd);
    exp_t e;
    e.lat = e_lat; e.err = e_err; e.rdata = e_rd;
    q.push_back(e);
    issue(ld, st, f3, addr, wd, ok);
    chk({tag, "_ready_acc"}, req_ready, 0);
    chk({tag, "_mem_en"}, mem_en, !e_err);
    chk({tag, "_mem_we"}, mem_we, e_we);
    if (!e_err) chk({tag, "_mem_addr"}, mem_addr, addr[9:2]);
    if (st && !e_err) chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
    wait_resp(tag);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; load = 1'b0; store = 1'b0;
    func3 = 3'b000; address = 32'd0; wdata = 32'd0; addr_ok = 1'b1;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_resp_valid", resp_valid, 0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); req_valid = 1'b1;
    @(posedge clk); #1;
    chk("noop_busy", busy, 0);
    chk("noop_mem_en", mem_en, 0);
    chk("noop_resp", resp_valid, 0);
    req_valid = 1'b0;

    xact("sw",  0, 1, 3'b010, 32'h10, 32'h12345678, 1, 0, 32'h0,        2, 4'b1111, 32'h12345678);
    xact("lw",  1, 0, 3'b010, 32'h10, 32'h0,        1, 0, 32'h12345678, 3, 4'b0000, 32'h0);
    xact("sb",  0, 1, 3'b000, 32'h11, 32'h000000A5, 1, 0, 32'h0,        2, 4'b0010, 32'hA5A5A5A5);
    xact("lb",  1, 0, 3'b000, 32'h11, 32'h0,        1, 0, 32'hFFFFFFA5, 3, 4'b0000, 32'h0);
    xact("lbu", 1, 0, 3'b100, 32'h11, 32'h0,        1, 0, 32'h000000A5, 3, 4'b0000, 32'h0);
    xact("lb0", 1, 0, 3'b000, 32'h10, 32'h0,        1, 0, 32'h00000078, 3, 4'b0000, 32'h0);
    xact("sh",  0, 1, 3'b001, 32'h12, 32'h0000BEEF, 1, 0, 32'h0,        2, 4'b1100, 32'hBEEFBEEF);
    xact("lh",  1, 0, 3'b001, 32'h12, 32'h0,        1, 0, 32'hFFFFBEEF, 3, 4'b0000, 32'h0);
    xact("lhu", 1, 0, 3'b101, 32'h12, 32'h0,        1, 0, 32'h0000BEEF, 3, 4'b0000, 32'h0);
    xact("lhlo",1, 0, 3'b001, 32'h10, 32'h0,        1, 0, 32'hFFFFA578, 3, 4'b0000, 32'h0);

    xact("e_addr",  1, 0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h0, 1, 4'b0000, 32'h0);
    xact("e_ldst",  1, 1, 3'b010, 32'h10, 32'h0, 1, 1, 32'h0, 1, 4'b0000, 32'h0);
    xact("e_f011",  1, 0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0, 1, 4'b0000, 32'h0);
    xact("e_stu",   0, 1, 3'b100, 32'h10, 32'hFF, 1, 1, 32'h0, 1, 4'b0000, 32'h0);

    // Request held high across a whole load: re-accepted only once back in IDLE.
    begin
      exp_t e;
      e.lat = 3; e.err = 1'b0; e.rdata = 32'hBEEFA578;
      q.push_back(e);
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b1; load = 1'b1; store = 1'b0; func3 = 3'b010; address = 32'h10; addr_ok = 1'b1;
    @(posedge clk); #1;
    chk("b2b1_mem_en", mem_en, 1);
    wait_resp("b2b1");
    @(posedge clk); #1;
    chk("b2b2_reaccept_en", mem_en, 1);
    chk("b2b2_reaccept_ready", req_ready, 0);
    req_valid = 1'b0; load = 1'b0;
    wait_resp("b2b2");

    // Reset asserted mid-load during WAIT drops the request.
    issue(1, 0, 3'b010, 32'h10, 32'h0, 1);
    @(posedge clk); #2;
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_mem_en", mem_en, 0);
    chk("rstmid_mem_we", mem_we, 0);
    chk("rstmid_resp", resp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_resp", resp_valid, 0);
    end
    xact("sw2", 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 1, 0, 32'h0,        2, 4'b1111, 32'hCAFEF00D);
    xact("lw2", 1, 0, 3'b010, 32'h20, 32'h0,        1, 0, 32'hCAFEF00D, 3, 4'b0000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
